// File: rtl/l1_cache_pkg.sv
// Shared definitions for the L1 data cache: controller states, word size and a byte-merge helper.
// No logic here, so there is no latency or backpressure to describe.
package l1_cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_REFILL,
    S_RESPOND
  } state_t;

  localparam int WORD_BYTES = 4;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [WORD_BYTES-1:0] strb);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/l1_cache_way.sv
// One cache way: tag array plus data array, one-cycle synchronous read, byte-enabled word write.
// Always accepts reads and writes, so it never applies backpressure.
module l1_cache_way
  import l1_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = 6,
  parameter int WIW         = 2,
  parameter int TAG_WIDTH   = 22
) (
  input  logic                   clk,
  input  logic [INDEX_WIDTH-1:0] i_rd_idx,
  input  logic [WIW-1:0]         i_rd_word,
  output logic [TAG_WIDTH-1:0]   o_tag,
  output logic [31:0]            o_rdata,
  input  logic                   i_tag_we,
  input  logic [TAG_WIDTH-1:0]   i_tag_wdata,
  input  logic                   i_data_we,
  input  logic [INDEX_WIDTH-1:0] i_wr_idx,
  input  logic [WIW-1:0]         i_wr_word,
  input  logic [31:0]            i_wdata,
  input  logic [WORD_BYTES-1:0]  i_wstrb
);

  logic [TAG_WIDTH-1:0] r_tags [2**INDEX_WIDTH];
  logic [31:0]          r_data [2**(INDEX_WIDTH+WIW)];

  always_ff @(posedge clk) begin
    if (i_tag_we) r_tags[i_wr_idx] <= i_tag_wdata;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (i_data_we && i_wstrb[b]) r_data[{i_wr_idx, i_wr_word}][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    o_tag   <= r_tags[i_rd_idx];
    o_rdata <= r_data[{i_rd_idx, i_rd_word}];
  end

endmodule

// File: rtl/l1_data_cache_sa.sv
// Set-associative write-back/write-allocate L1 data cache; hits respond 2 cycles after accept.
// One request at a time (req_ready only when idle); memory words wait on mem_req_ready, one read outstanding.
module l1_data_cache_sa
  import l1_cache_pkg::*;
#(
  parameter int OFFSET_WIDTH = 4,
  parameter int INDEX_WIDTH  = 6,
  parameter int WAYS         = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [WORD_BYTES-1:0] req_wstrb,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  cache_miss,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [31:0]           mem_req_addr,
  output logic [31:0]           mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [31:0]           mem_resp_rdata
);

  localparam int TAG_WIDTH = 32 - OFFSET_WIDTH - INDEX_WIDTH;
  localparam int WPB       = 2**(OFFSET_WIDTH-2);
  localparam int WIW       = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH-2 : 1;
  localparam int SETS      = 2**INDEX_WIDTH;
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_t r_state, w_state_nxt;

  logic                  r_write;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [INDEX_WIDTH-1:0] r_idx;
  logic [WIW-1:0]        r_word;
  logic [31:0]           r_wdata;
  logic [WORD_BYTES-1:0] r_wstrb;
  logic [WAY_W-1:0]      r_victim;
  logic [TAG_WIDTH-1:0]  r_vtag;
  logic [WIW-1:0]        r_cnt;
  logic                  r_wb_vld;
  logic                  r_rd_out;
  logic [31:0]           r_rdata;
  logic [SETS-1:0]       r_valid [WAYS];
  logic [SETS-1:0]       r_dirty [WAYS];

  logic [TAG_WIDTH-1:0]   w_req_tag;
  logic [INDEX_WIDTH-1:0] w_req_idx;
  logic [WIW-1:0]         w_req_word;
  logic [1:0]             w_unused_addr_lsb;
  logic [INDEX_WIDTH-1:0] w_rd_idx;
  logic [WIW-1:0]         w_rd_word;
  logic [TAG_WIDTH-1:0]   w_way_tag   [WAYS];
  logic [31:0]            w_way_rdata [WAYS];
  logic                   w_hit;
  logic [WAY_W-1:0]       w_hit_way;
  logic [WAY_W-1:0]       w_rr;
  logic [WAY_W-1:0]       w_victim;
  logic                   w_victim_dirty;
  logic                   w_mem_fire;
  logic                   w_resp_take;
  logic                   w_last;
  logic                   w_refill_done;
  logic [WAYS-1:0]        w_data_we;
  logic [WAYS-1:0]        w_tag_we;
  logic [WIW-1:0]         w_wr_word;
  logic [31:0]            w_wdata;
  logic [WORD_BYTES-1:0]  w_wstrb;
  logic [TAG_WIDTH-1:0]   w_addr_tag;

  assign w_req_tag         = req_addr[31 -: TAG_WIDTH];
  assign w_req_idx         = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_unused_addr_lsb = req_addr[1:0];

  if (OFFSET_WIDTH > 2) begin : g_word
    assign w_req_word = req_addr[OFFSET_WIDTH-1:2];
  end else begin : g_word_one
    assign w_req_word = '0;
  end

  // The arrays are read at the accept edge so tags and data are ready in LOOKUP.
  assign w_rd_idx  = (r_state == S_IDLE) ? w_req_idx : r_idx;
  assign w_rd_word = (r_state == S_IDLE)      ? w_req_word :
                     (r_state == S_WRITEBACK) ? r_cnt : r_word;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    l1_cache_way #(
      .INDEX_WIDTH(INDEX_WIDTH),
      .WIW        (WIW),
      .TAG_WIDTH  (TAG_WIDTH)
    ) u_way (
      .clk        (clk),
      .i_rd_idx   (w_rd_idx),
      .i_rd_word  (w_rd_word),
      .o_tag      (w_way_tag[g]),
      .o_rdata    (w_way_rdata[g]),
      .i_tag_we   (w_tag_we[g]),
      .i_tag_wdata(r_tag),
      .i_data_we  (w_data_we[g]),
      .i_wr_idx   (r_idx),
      .i_wr_word  (w_wr_word),
      .i_wdata    (w_wdata),
      .i_wstrb    (w_wstrb)
    );
  end

  assign w_mem_fire    = mem_req_valid && mem_req_ready;
  assign w_resp_take   = (r_state == S_REFILL) && r_rd_out && mem_resp_valid;
  assign w_last        = (r_cnt == WIW'(WPB-1));
  assign w_refill_done = w_resp_take && w_last;

  if (WAYS > 1) begin : g_rr
    logic [WAY_W-1:0] r_rr [SETS];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
      end else if (w_refill_done) begin
        r_rr[r_idx] <= r_rr[r_idx] + 1'b1;
      end
    end
    assign w_rr = r_rr[r_idx];
  end else begin : g_no_rr
    assign w_rr = '0;
  end

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_victim  = w_rr;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w][r_idx] && (w_way_tag[w] == r_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!r_valid[w][r_idx]) w_victim = WAY_W'(w);
    end
    w_victim_dirty = r_valid[w_victim][r_idx] && r_dirty[w_victim][r_idx];
  end

  // A pending store is folded into its refill word so the line lands already merged.
  always_comb begin
    w_data_we = '0;
    w_tag_we  = '0;
    w_wr_word = r_word;
    w_wdata   = r_wdata;
    w_wstrb   = r_wstrb;
    if ((r_state == S_LOOKUP) && w_hit && r_write) w_data_we[w_hit_way] = 1'b1;
    if (w_resp_take) begin
      w_data_we[r_victim] = 1'b1;
      w_wr_word           = r_cnt;
      w_wstrb             = '1;
      w_wdata             = (r_write && (r_cnt == r_word)) ?
                            merge_bytes(mem_resp_rdata, r_wdata, r_wstrb) : mem_resp_rdata;
      if (w_last) w_tag_we[r_victim] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:      if (req_valid) w_state_nxt = S_LOOKUP;
      S_LOOKUP:    w_state_nxt = w_hit ? S_RESPOND : (w_victim_dirty ? S_WRITEBACK : S_REFILL);
      S_WRITEBACK: if (w_mem_fire && w_last) w_state_nxt = S_REFILL;
      S_REFILL:    if (w_refill_done) w_state_nxt = S_RESPOND;
      S_RESPOND:   w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (r_state == S_IDLE);
    resp_valid    = (r_state == S_RESPOND);
    resp_rdata    = resp_valid ? r_rdata : '0;
    cache_miss    = (r_state == S_LOOKUP) && !w_hit;
    mem_req_write = (r_state == S_WRITEBACK) && r_wb_vld;
    mem_req_valid = mem_req_write || ((r_state == S_REFILL) && !r_rd_out);
    w_addr_tag    = mem_req_write ? r_vtag : r_tag;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    if (mem_req_valid) mem_req_addr = {w_addr_tag, r_idx, {OFFSET_WIDTH{1'b0}}} | (32'(r_cnt) << 2);
    if (mem_req_write) mem_req_wdata = w_way_rdata[r_victim];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_write  <= 1'b0;
      r_tag    <= '0;
      r_idx    <= '0;
      r_word   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_victim <= '0;
      r_vtag   <= '0;
      r_cnt    <= '0;
      r_wb_vld <= 1'b0;
      r_rd_out <= 1'b0;
      r_rdata  <= '0;
      for (int w = 0; w < WAYS; w++) begin
        r_valid[w] <= '0;
        r_dirty[w] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_tag   <= w_req_tag;
            r_idx   <= w_req_idx;
            r_word  <= w_req_word;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
          end
        end
        S_LOOKUP: begin
          r_cnt    <= '0;
          r_wb_vld <= 1'b0;
          r_rd_out <= 1'b0;
          r_victim <= w_victim;
          r_vtag   <= w_way_tag[w_victim];
          r_rdata  <= '0;
          if (w_hit) begin
            if (!r_write) r_rdata <= w_way_rdata[w_hit_way];
            if (r_write && (|r_wstrb)) r_dirty[w_hit_way][r_idx] <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          // One idle cycle per word lets the synchronous read present the next word.
          if (!r_wb_vld) begin
            r_wb_vld <= 1'b1;
          end else if (mem_req_ready) begin
            r_wb_vld <= 1'b0;
            r_cnt    <= r_cnt + 1'b1;
          end
        end
        S_REFILL: begin
          if (w_mem_fire) r_rd_out <= 1'b1;
          if (w_resp_take) begin
            r_rd_out <= 1'b0;
            r_cnt    <= r_cnt + 1'b1;
            if (!r_write && (r_cnt == r_word)) r_rdata <= mem_resp_rdata;
            if (w_last) begin
              r_valid[r_victim][r_idx] <= 1'b1;
              r_dirty[r_victim][r_idx] <= r_write && (|r_wstrb);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
